incr_pipe_sched: RTL and testbench

Round-robin scheduler that shares the two-register increment datapath (capture register, +INCR adder, output register) among NREQ requesters using valid/ready handshakes. It arbitrates each cycle, tags every accepted word with its requester ID, and stalls the pipeline under downstream backpressure. Each result returns exactly two cycles after acceptance, or later if stalled. It sits between the requesting blocks and the result consumer and replaces hard-wired feeding of the datapath.

---
 rtl/incr_sched_pkg.sv | 19 +
 rtl/incr_pipe_sched_rr_arbiter.sv | 49 ++++
 rtl/incr_pipe_sched.sv | 90 +++++++++
 tb/tb_incr_pipe_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/incr_sched_pkg.sv
// Shared constants, ID-width helper and stage record for the incrementing scheduler.
package incr_sched_pkg;

    localparam int DEF_NREQ = 2;
    localparam int DEF_DW   = 8;
    localparam int DEF_INCR = 1;

    // A single requester still needs one ID bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                            valid;
        logic [id_width(DEF_NREQ)-1:0]   id;
        logic [DEF_DW-1:0]               data;
    } stage_t;

endpackage

// File: rtl/incr_pipe_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last requester that completed a handshake.
module rr_arbiter
    import incr_sched_pkg::*;
#(
    parameter  int N  = DEF_NREQ,
    localparam int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last;

    // Scan from farthest to nearest candidate so the nearest valid one overwrites the rest.
    always_comb begin
        int            cand;
        logic [IW-1:0] idx;
        cand      = 0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = int'(last) + 1 + k;
                if (cand >= N) cand = cand - N;
                idx = IW'(cand);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(N - 1);
        end else if (adv) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/incr_pipe_sched.sv
// Shares a capture-register / +INCR / output-register datapath among NREQ requesters.
module incr_pipe_sched
    import incr_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int DW   = DEF_DW,
    parameter  int INCR = DEF_INCR,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_wrap,
    output logic              busy
);

    logic            adv1;
    logic            adv2;
    logic            hs;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic [DW-1:0]   s1_data;
    logic [DW-1:0]   sel_data;
    logic [DW:0]     sum;

    assign adv2      = !rsp_valid || rsp_ready;
    assign adv1      = !s1_valid || adv2;
    assign req_ready = grant & {NREQ{en & adv1}};
    assign hs        = |(req_valid & req_ready);
    assign sum       = {1'b0, s1_data} + {1'b0, DW'(INCR)};
    assign busy      = s1_valid | rsp_valid;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (en),
        .adv       (hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) sel_data = req_data[i*DW +: DW];
        end
    end

    // S1 empties when it advances without a new handshake, so bubbles never carry stale data forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_data  <= '0;
        end else if (adv1) begin
            s1_valid <= hs;
            if (hs) begin
                s1_id   <= grant_idx;
                s1_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_wrap  <= 1'b0;
        end else if (adv2) begin
            rsp_valid <= s1_valid;
            rsp_id    <= s1_id;
            rsp_data  <= sum[DW-1:0];
            rsp_wrap  <= sum[DW];
        end
    end

endmodule

// File: tb/tb_incr_pipe_sched.sv
// Self-checking bench for incr_pipe_sched: vector table plus hand-written multi-cycle sequences.
module tb_incr_pipe_sched;
    import incr_sched_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int INCR = 1;
    localparam int IDW  = id_width(NREQ);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [DW-1:0]     wdata [NREQ];
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_wrap;
    logic              busy;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           wrap;
    } rsp_t;

    typedef struct {
        int            r;
        logic [DW-1:0] din;
        logic [DW-1:0] dexp;
        logic          wexp;
    } vec_t;

    rsp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = wdata[i];
    end

    incr_pipe_sched #(
        .NREQ(NREQ),
        .DW  (DW),
        .INCR(INCR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_wrap  (rsp_wrap),
        .busy      (busy)
    );

    // Requesters must hold valid and data until accepted.
    for (genvar g = 0; g < NREQ; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[g] && !req_ready[g]) |=> (req_valid[g] && $stable(req_data[g*DW +: DW])))
        else $error("[TB] FAIL protocol requester %0d dropped valid or changed data", g);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard: compare the head while held, pop it when consumed.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got id %0h data %0h expected no response", rsp_id, rsp_data);
            end else begin
                checkOutput(rsp_ready ? "rsp_id" : "held_rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                checkOutput(rsp_ready ? "rsp_data" : "held_rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                checkOutput(rsp_ready ? "rsp_wrap" : "held_rsp_wrap", 32'(rsp_wrap), 32'(exp_q[0].wrap));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        req_valid = '0;
        en        = 1'b1;
        rsp_ready = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic expectRsp(input int r, input logic [DW-1:0] d, input logic w);
        rsp_t e;
        e.id   = IDW'(r);
        e.data = d;
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    task automatic sendWord(input int r, input logic [DW-1:0] d);
        int   n;
        logic seen;
        wdata[r]     = d;
        req_valid[r] = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = req_valid[r] && req_ready[r];
            n++;
        end
        checkOutput("handshake", 32'(seen), 32'd1);
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic feed(input int r, input logic [DW-1:0] d0, input int cnt);
        for (int k = 0; k < cnt; k++) sendWord(r, DW'(int'(d0) + k));
    endtask

    task automatic applyStimulus(input vec_t v);
        expectRsp(v.r, v.dexp, v.wexp);
        sendWord(v.r, v.din);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        checkOutput("drain_busy", 32'(busy), 32'd0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{r: 1, din: 8'hFF, dexp: 8'h00, wexp: 1'b1};
        vecs[1] = '{r: 0, din: 8'h7F, dexp: 8'h80, wexp: 1'b0};
        vecs[2] = '{r: 1, din: 8'h00, dexp: 8'h01, wexp: 1'b0};
        vecs[3] = '{r: 0, din: 8'hFE, dexp: 8'hFF, wexp: 1'b0};
        vecs[4] = '{r: 1, din: 8'h80, dexp: 8'h81, wexp: 1'b0};
        vecs[5] = '{r: 0, din: 8'hFF, dexp: 8'h00, wexp: 1'b1};

        rst_n     = 1'b1;
        en        = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) wdata[i] = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_rsp_wrap", 32'(rsp_wrap), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single word latency
        expectRsp(0, 8'h42, 1'b0);
        wdata[0]     = 8'h41;
        req_valid[0] = 1'b1;
        @(negedge clk);
        checkOutput("accept_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("lat1_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("lat1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("lat2_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        drain();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
        drain();

        // Round robin with both requesters streaming
        applyReset();
        for (int k = 0; k < 3; k++) begin
            expectRsp(0, DW'(8'h11 + k), 1'b0);
            expectRsp(1, DW'(8'h21 + k), 1'b0);
        end
        fork
            feed(0, 8'h10, 3);
            feed(1, 8'h20, 3);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rsp_valid && n < 20);
                for (int k = 0; k < 6; k++) begin
                    if (k > 0) @(negedge clk);
                    checkOutput("no_bubble", 32'(rsp_valid), 32'd1);
                end
            end
        join
        tick();
        drain();

        // Backpressure for three cycles in the middle of a stream
        for (int k = 0; k < 4; k++) expectRsp(0, DW'(8'h31 + k), 1'b0);
        fork
            feed(0, 8'h30, 4);
            begin
                repeat (3) tick();
                rsp_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
                    checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                end
                tick();
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Disable with both stages full, then drain and resume
        applyReset();
        rsp_ready = 1'b0;
        expectRsp(0, 8'h51, 1'b0);
        expectRsp(1, 8'h61, 1'b0);
        fork
            sendWord(0, 8'h50);
            sendWord(1, 8'h60);
        join
        en           = 1'b0;
        wdata[0]     = 8'h70;
        wdata[1]     = 8'h80;
        req_valid    = '1;
        expectRsp(0, 8'h71, 1'b0);
        expectRsp(1, 8'h81, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("dis_req_ready", 32'(req_ready), 32'd0);
            checkOutput("dis_busy", 32'(busy), 32'd1);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain0_busy", 32'(busy), 32'd1);
        checkOutput("drain0_req_ready", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("drain1_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("drain2_busy", 32'(busy), 32'd0);
        tick();
        en = 1'b1;
        @(negedge clk);
        checkOutput("resume_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("resume_grant2", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        drain();

        // Reset with two words in flight, pointer left at requester 0
        rsp_ready = 1'b0;
        expectRsp(1, 8'h91, 1'b0);
        expectRsp(0, 8'hA1, 1'b0);
        sendWord(1, 8'h90);
        sendWord(0, 8'hA0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("mid_reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        exp_q.delete();
        rsp_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        wdata[0]  = 8'hC0;
        wdata[1]  = 8'hD0;
        req_valid = '1;
        expectRsp(0, 8'hC1, 1'b0);
        expectRsp(1, 8'hD1, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_grant2", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
